counted_coupled_cell: RTL and testbench



---
 rtl/counted_coupled_cell.sv | 133 +++++++++++++
 tb/tb_counted_coupled_cell.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/counted_coupled_cell.sv
// Clocked Ising coupling cell: din phase edges are delayed by a weight-dependent
// cycle count against a free-running timestamp, with a small FIFO of pending edges.
module counted_coupled_cell #(
    parameter int WEIGHT_WIDTH = 4,
    parameter int BASE_DELAY   = 9,
    parameter int FIFO_DEPTH   = 4,
    parameter int TS_WIDTH     = 8
) (
    input  logic        clk,
    input  logic        axi_rst,
    input  logic        ising_rst,
    input  logic        din,
    input  logic        sout,
    output logic        dout,
    input  logic        wready,
    input  logic        wr_addr_match,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [WEIGHT_WIDTH-1:0] weight_reg;
    logic [7:0]              drop_cnt_reg;
    logic                    overflow_reg;
    logic [TS_WIDTH-1:0]     ts_reg;
    logic                    din_q_reg;
    logic                    dout_reg;
    logic [TS_WIDTH-1:0]     last_target_reg;
    logic [TS_WIDTH-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W:0]          count_reg;

    logic                    osc_reset;
    logic                    wr_en;
    logic                    din_edge;
    logic                    mismatch;
    logic signed [WEIGHT_WIDTH-1:0] weight_s;
    logic signed [31:0]      w_ext;
    logic signed [31:0]      d_raw;
    logic [TS_WIDTH-1:0]     d_ts;
    logic [TS_WIDTH-1:0]     cand;
    logic [TS_WIDTH-1:0]     diff;
    logic [TS_WIDTH-1:0]     target;
    logic                    pop;
    logic                    push;
    logic                    drop;
    logic [PTR_W:0]          count_after_pop;
    logic                    unused_wdata;

    assign osc_reset    = axi_rst || ising_rst;
    assign wr_en        = wready && wr_addr_match;
    assign unused_wdata = ^wdata[31:WEIGHT_WIDTH];
    assign dout         = dout_reg;

    always_comb begin
        din_edge = din != din_q_reg;
        mismatch = din ^ sout;
        weight_s = signed'(weight_reg);
        w_ext    = 32'(weight_s);
        d_raw    = mismatch ? (32'(BASE_DELAY) + w_ext) : (32'(BASE_DELAY) - w_ext);
        // Parameter rule keeps D >= 1; the clamp only guards a misconfigured instance.
        d_ts     = (d_raw < 32'sd1) ? TS_WIDTH'(1) : d_raw[TS_WIDTH-1:0];
        cand     = ts_reg + d_ts;

        pop             = (count_reg != '0) && (fifo_mem[rd_ptr_reg] == ts_reg);
        count_after_pop = count_reg - {{PTR_W{1'b0}}, pop};
        push            = din_edge && (count_after_pop != FULL_CNT);
        drop            = din_edge && (count_after_pop == FULL_CNT);

        // Force strictly increasing targets so toggles stay in order and never merge.
        diff   = cand - last_target_reg;
        target = cand;
        if ((count_after_pop != '0) && (diff[TS_WIDTH-1] || (diff == '0))) begin
            target = last_target_reg + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (osc_reset) begin
            ts_reg          <= '0;
            din_q_reg       <= 1'b0;
            dout_reg        <= 1'b0;
            last_target_reg <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
        end else begin
            ts_reg    <= ts_reg + TS_WIDTH'(1);
            din_q_reg <= din;
            if (pop) begin
                dout_reg   <= ~dout_reg;
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push) begin
                wr_ptr_reg      <= wr_ptr_reg + PTR_W'(1);
                last_target_reg <= target;
            end
            count_reg <= count_after_pop + {{PTR_W{1'b0}}, push};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !osc_reset) begin
            fifo_mem[wr_ptr_reg] <= target;
        end
    end

    always_ff @(posedge clk) begin
        if (axi_rst) begin
            weight_reg   <= '0;
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else if (wr_en) begin
            weight_reg   <= wdata[WEIGHT_WIDTH-1:0];
            drop_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else if (drop && !ising_rst) begin
            overflow_reg <= 1'b1;
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    always_comb begin
        rdata                     = '0;
        rdata[WEIGHT_WIDTH-1:0]   = weight_reg;
        rdata[23:16]              = drop_cnt_reg;
        rdata[31]                 = overflow_reg;
    end
endmodule

// File: tb/tb_counted_coupled_cell.sv
// Directed bench for counted_coupled_cell: delay per weight/mismatch, ordering,
// FIFO overflow accounting and both resets.
module tb_counted_coupled_cell;
    logic        clk = 1'b0;
    logic        axi_rst = 1'b0;
    logic        ising_rst = 1'b0;
    logic        din = 1'b0;
    logic        sout = 1'b0;
    logic        dout;
    logic        wready = 1'b0;
    logic        wr_addr_match = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;

    int n_cmp = 0;
    int n_bad = 0;

    counted_coupled_cell dut (
        .clk(clk), .axi_rst(axi_rst), .ising_rst(ising_rst), .din(din), .sout(sout),
        .dout(dout), .wready(wready), .wr_addr_match(wr_addr_match), .wdata(wdata),
        .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_weight(input logic [31:0] v, input logic hit);
        wready = 1'b1;
        wr_addr_match = hit;
        wdata = v;
        tick();
        wready = 1'b0;
        wr_addr_match = 1'b0;
        wdata = '0;
    endtask

    task automatic osc_reset();
        din = 1'b0;
        ising_rst = 1'b1;
        tick();
        ising_rst = 1'b0;
        tick();
    endtask

    // Drive din/sout after an edge and return cycles from the sampling posedge to the dout toggle.
    task automatic edge_latency(input logic new_din, input logic new_sout, output int lat);
        logic old;
        int m;
        old = dout;
        din = new_din;
        sout = new_sout;
        m = 0;
        lat = -1;
        while (m < 64) begin
            tick();
            m++;
            if (dout !== old) begin
                lat = m - 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        axi_rst = 1'b1;
        tick();
        tick();
        axi_rst = 1'b0;
        tick();
        n_cmp++;
        if (dout !== 1'b0) begin n_bad++; $display("FAIL reset_dout: got %0b want 0", dout); end
        n_cmp++;
        if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %08h want 00000000", rdata); end
        $display("test_reset: dout=%0b rdata=%08h", dout, rdata);
    endtask

    task automatic test_weight_zero();
        int lat;
        edge_latency(1'b1, 1'b1, lat);
        n_cmp++;
        if (lat !== 9) begin n_bad++; $display("FAIL w0_latency: got %0d want 9", lat); end
        n_cmp++;
        if (rdata !== 32'h0) begin n_bad++; $display("FAIL w0_rdata: got %08h want 00000000", rdata); end
        $display("test_weight_zero: latency=%0d", lat);
    endtask

    task automatic test_positive_weight();
        int lat;
        write_weight(32'h3, 1'b1);
        n_cmp++;
        if (rdata !== 32'h3) begin n_bad++; $display("FAIL pos_rdata: got %08h want 00000003", rdata); end
        osc_reset();
        n_cmp++;
        if (dout !== 1'b0) begin n_bad++; $display("FAIL pos_osc_reset_dout: got %0b want 0", dout); end
        edge_latency(1'b1, 1'b0, lat);
        n_cmp++;
        if (lat !== 12) begin n_bad++; $display("FAIL pos_mismatch_latency: got %0d want 12", lat); end
        $display("test_positive_weight: mismatch latency=%0d", lat);
        osc_reset();
        edge_latency(1'b1, 1'b1, lat);
        n_cmp++;
        if (lat !== 6) begin n_bad++; $display("FAIL pos_match_latency: got %0d want 6", lat); end
        $display("test_positive_weight: match latency=%0d", lat);
        write_weight(32'h5, 1'b0);
        n_cmp++;
        if (rdata !== 32'h3) begin n_bad++; $display("FAIL miss_addr_write: got %08h want 00000003", rdata); end
        $display("test_positive_weight: non-matching write rdata=%08h", rdata);
    endtask

    task automatic test_negative_weight();
        int lat;
        write_weight(32'h8, 1'b1);
        n_cmp++;
        if (rdata !== 32'h8) begin n_bad++; $display("FAIL neg_rdata: got %08h want 00000008", rdata); end
        osc_reset();
        edge_latency(1'b1, 1'b0, lat);
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL neg_mismatch_latency: got %0d want 1", lat); end
        $display("test_negative_weight: mismatch latency=%0d", lat);
        osc_reset();
        edge_latency(1'b1, 1'b1, lat);
        n_cmp++;
        if (lat !== 17) begin n_bad++; $display("FAIL neg_match_latency: got %0d want 17", lat); end
        $display("test_negative_weight: match latency=%0d", lat);
    endtask

    task automatic test_ordering();
        int k;
        logic old;
        write_weight(32'h7, 1'b1);
        osc_reset();
        din = 1'b1;
        sout = 1'b0;
        tick();
        din = 1'b0;
        sout = 1'b0;
        old = dout;
        k = 0;
        while (k < 64) begin
            tick();
            k++;
            if (dout !== old) break;
        end
        n_cmp++;
        if (k !== 16) begin n_bad++; $display("FAIL order_first_toggle: got %0d want 16", k); end
        n_cmp++;
        if (dout !== 1'b1) begin n_bad++; $display("FAIL order_first_level: got %0b want 1", dout); end
        tick();
        n_cmp++;
        if (dout !== 1'b0) begin n_bad++; $display("FAIL order_second_toggle: got %0b want 0 at 17", dout); end
        $display("test_ordering: first toggle at %0d, dout after next cycle=%0b", k, dout);
    endtask

    task automatic test_overflow();
        int toggles;
        logic old;
        write_weight(32'h0, 1'b1);
        osc_reset();
        for (int i = 0; i < 6; i++) begin
            din = ~din;
            tick();
        end
        n_cmp++;
        if (rdata !== 32'h8002_0000) begin n_bad++; $display("FAIL ovf_rdata: got %08h want 80020000", rdata); end
        toggles = 0;
        for (int i = 0; i < 30; i++) begin
            old = dout;
            tick();
            if (dout !== old) toggles++;
        end
        n_cmp++;
        if (toggles !== 4) begin n_bad++; $display("FAIL ovf_toggles: got %0d want 4", toggles); end
        n_cmp++;
        if (dout !== 1'b0) begin n_bad++; $display("FAIL ovf_final_dout: got %0b want 0", dout); end
        write_weight(32'h0, 1'b1);
        n_cmp++;
        if (rdata !== 32'h0) begin n_bad++; $display("FAIL ovf_clear: got %08h want 00000000", rdata); end
        $display("test_overflow: toggles=%0d rdata after clear=%08h", toggles, rdata);
    endtask

    task automatic test_mid_reset();
        int toggles;
        logic old;
        write_weight(32'h5, 1'b1);
        osc_reset();
        sout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = ~din;
            tick();
        end
        din = 1'b0;
        ising_rst = 1'b1;
        tick();
        ising_rst = 1'b0;
        n_cmp++;
        if (dout !== 1'b0) begin n_bad++; $display("FAIL midrst_dout: got %0b want 0", dout); end
        toggles = 0;
        for (int i = 0; i < 30; i++) begin
            old = dout;
            tick();
            if (dout !== old) toggles++;
        end
        n_cmp++;
        if (toggles !== 0) begin n_bad++; $display("FAIL midrst_toggles: got %0d want 0", toggles); end
        n_cmp++;
        if (rdata !== 32'h5) begin n_bad++; $display("FAIL midrst_weight: got %08h want 00000005", rdata); end
        axi_rst = 1'b1;
        tick();
        axi_rst = 1'b0;
        n_cmp++;
        if (rdata !== 32'h0) begin n_bad++; $display("FAIL axirst_weight: got %08h want 00000000", rdata); end
        $display("test_mid_reset: toggles=%0d rdata after axi_rst=%08h", toggles, rdata);
    endtask

    initial begin
        test_reset();
        test_weight_zero();
        test_positive_weight();
        test_negative_weight();
        test_ordering();
        test_overflow();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
